// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg -- shared definitions for the PC generator slice.
//   redir_src_e  : redirect source, encoded in ascending priority order
//   pend_state_e : redirect-pending state of the PC generator
//   DEF_RESET_PC / DEF_EXC_VEC : default word addresses for pc_gen
//   outranks()   : true when request a displaces latched request b
package pc_gen_pkg;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_JR   = 3'd3,
        SRC_ERET = 3'd4,
        SRC_EXC  = 3'd5
    } redir_src_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_PEND = 1'b1
    } pend_state_e;

    localparam logic [29:0] DEF_RESET_PC = 30'h00000C00;
    localparam logic [29:0] DEF_EXC_VEC  = 30'h00001060;

    // An exception always displaces whatever is latched, even another exception.
    function automatic logic outranks(redir_src_e a, redir_src_e b);
        return (a != SRC_NONE) && ((a > b) || (a == SRC_EXC));
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if -- request/response bundle between the pipeline and pc_gen.
//   master : pipeline side (drives stall and redirect requests, sees pc/RAS)
//   slave  : pc_gen side
//   Requests : stall, exc_req, eret_req/epc, jr_req/jr_target,
//              jmp_req/instr_index, br_taken/br_offset, redir_base, call, ret
//   Responses: pc, redirect, pend, ras_top, ras_valid
interface pc_gen_if #(
    parameter int unsigned ADDR_W = 30
);
    logic              stall;
    logic              exc_req;
    logic              eret_req;
    logic [ADDR_W-1:0] epc;
    logic              jr_req;
    logic [ADDR_W+1:0] jr_target;
    logic              jmp_req;
    logic [25:0]       instr_index;
    logic              br_taken;
    logic [15:0]       br_offset;
    logic [ADDR_W-1:0] redir_base;
    logic              call;
    logic              ret;
    logic [ADDR_W-1:0] pc;
    logic              redirect;
    logic              pend;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_valid;

    modport master (
        output stall, exc_req, eret_req, epc, jr_req, jr_target, jmp_req,
               instr_index, br_taken, br_offset, redir_base, call, ret,
        input  pc, redirect, pend, ras_top, ras_valid
    );

    modport slave (
        input  stall, exc_req, eret_req, epc, jr_req, jr_target, jmp_req,
               instr_index, br_taken, br_offset, redir_base, call, ret,
        output pc, redirect, pend, ras_top, ras_valid
    );
endinterface

// File: rtl/pc_gen_ras.sv
// pc_gen_ras -- return-address stack as a circular buffer.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i     : push data_i (overwrites the oldest entry when full)
//   pop_i      : pop top entry (no effect when empty)
//   push_i & pop_i : replace the top entry (plain push when empty)
//   data_i     : return word address to push
//   top_o      : top entry, 0 when empty
//   valid_o    : stack non-empty
module pc_gen_ras #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [ADDR_W-1:0] data_i,
    output logic [ADDR_W-1:0] top_o,
    output logic              valid_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  ptr_q;   // next free slot
    logic [PTR_W:0]    cnt_q;
    logic [PTR_W-1:0]  top_idx;

    assign top_idx = ptr_q - 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            ptr_q <= '0;
            cnt_q <= '0;
        end else if (push_i && pop_i && (cnt_q != '0)) begin
            mem_q[top_idx] <= data_i;
        end else if (push_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + 1'b1;
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_q <= top_idx;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_comb begin
        valid_o = (cnt_q != '0);
        top_o   = valid_o ? mem_q[top_idx] : '0;
    end
endmodule

// File: rtl/pc_gen.sv
// pc_gen -- fetch PC generator with prioritised redirects, stall-time
// redirect latching and an optional return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_gen_if.slave (requests in; pc, redirect, pend,
//                ras_top, ras_valid out)
// Build option: define PC_GEN_RAS_EN to include the return-address stack
// (pc_gen_ras); otherwise call/ret are ignored and ras_top/ras_valid are 0.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 30,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC),
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    pc_gen_if.slave  bus
);
    pend_state_e       state_q, state_d;
    redir_src_e        pend_src_q, pend_src_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              redirect_q, redirect_d;

    redir_src_e        req_src;
    logic [ADDR_W-1:0] req_tgt;
    logic              take_new;
    redir_src_e        win_src;
    logic [ADDR_W-1:0] win_tgt;
    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_valid;

    // Same-cycle arbitration of incoming requests.
    always_comb begin
        req_src = SRC_NONE;
        req_tgt = '0;
        if (bus.exc_req) begin
            req_src = SRC_EXC;
            req_tgt = EXC_VEC;
        end else if (bus.eret_req) begin
            req_src = SRC_ERET;
            req_tgt = bus.epc;
        end else if (bus.jr_req) begin
            req_src = SRC_JR;
            req_tgt = bus.jr_target[ADDR_W+1:2];
        end else if (bus.jmp_req) begin
            req_src = SRC_JMP;
            req_tgt = {bus.redir_base[ADDR_W-1:26], bus.instr_index};
        end else if (bus.br_taken) begin
            req_src = SRC_BR;
            req_tgt = bus.redir_base + {{(ADDR_W-16){bus.br_offset[15]}}, bus.br_offset};
        end
    end

    // pend_src_q is SRC_NONE whenever nothing is latched, so one compare
    // covers both the idle and the pending case.
    always_comb begin
        take_new = outranks(req_src, pend_src_q);
        win_src  = take_new ? req_src : pend_src_q;
        win_tgt  = take_new ? req_tgt : pend_tgt_q;
        ras_push = take_new && ((req_src == SRC_JR) || (req_src == SRC_JMP)) && bus.call;
        ras_pop  = take_new && ((req_src == SRC_JR) || (req_src == SRC_JMP)) && bus.ret;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pend_src_q <= SRC_NONE;
            pend_tgt_q <= '0;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_src_q <= pend_src_d;
            pend_tgt_q <= pend_tgt_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pend_src_d = pend_src_q;
        pend_tgt_d = pend_tgt_q;
        pc_d       = pc_q;
        redirect_d = 1'b0;
        if (bus.stall) begin
            if (take_new) begin
                state_d    = ST_PEND;
                pend_src_d = req_src;
                pend_tgt_d = req_tgt;
            end
        end else if (win_src != SRC_NONE) begin
            pc_d       = win_tgt;
            redirect_d = 1'b1;
            state_d    = ST_RUN;
            pend_src_d = SRC_NONE;
            pend_tgt_d = '0;
        end else begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_comb begin
        bus.pc        = pc_q;
        bus.redirect  = redirect_q;
        bus.pend      = (state_q == ST_PEND);
        bus.ras_top   = ras_top;
        bus.ras_valid = ras_valid;
    end

`ifdef PC_GEN_RAS_EN
    pc_gen_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .data_i  (bus.redir_base),
        .top_o   (ras_top),
        .valid_o (ras_valid)
    );
    logic unused_bits;
    assign unused_bits = ^bus.jr_target[1:0];
`else
    localparam int unsigned RAS_DEPTH_UNUSED = RAS_DEPTH;
    assign ras_top   = '0;
    assign ras_valid = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{bus.jr_target[1:0], ras_push, ras_pop};
`endif
endmodule
